opr_sequencer: RTL

//   Sequencer for the phase-1 operand datapath. Fetches 11-bit instructions ({opcode[2:0], operand[7:0]})

---
 rtl/opr_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/opr_sequencer.sv
// opr_sequencer: fetches {opcode,operand} instructions, drives the OPR demux select/operand bus and pulses one datapath enable
// Ports: clk/rstn clock and async active-low reset; start begins at pc 0 from IDLE or HALT;
//   instr_req/pc/instr_valid/instr_data fetch handshake; OPR_sel/operand demux select and bus;
//   wtr_en/inc_en/reset_en/wta_en one-cycle strobes; dp_busy stalls the next fetch;
//   halted high in HALT; illegal sticky flag for opcode 110.
module opr_sequencer #(
  parameter int OPW = 8,
  parameter int PCW = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  output logic           instr_req,
  output logic [PCW-1:0] pc,
  input  logic           instr_valid,
  input  logic [OPW+2:0] instr_data,
  output logic [2:0]     OPR_sel,
  output logic [OPW-1:0] operand,
  output logic           wtr_en,
  output logic           inc_en,
  output logic           reset_en,
  output logic           wta_en,
  input  logic           dp_busy,
  output logic           halted,
  output logic           illegal
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, PULSE, WAIT, HALT} state_t;
  state_t state;
  logic [2:0] op;
  logic [OPW-1:0] arg;
  // EXEC is the cycle where OPR_sel is already stable; the strobe register is loaded on
  // leaving it, so each enable is visible for the single PULSE cycle that follows.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      op <= '0;
      arg <= '0;
      instr_req <= 1'b0;
      pc <= '0;
      OPR_sel <= '0;
      operand <= '0;
      wtr_en <= 1'b0;
      inc_en <= 1'b0;
      reset_en <= 1'b0;
      wta_en <= 1'b0;
      halted <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: if (start) begin
          pc <= '0;
          illegal <= 1'b0;
          halted <= 1'b0;
          instr_req <= 1'b1;
          state <= FETCH;
        end
        FETCH: if (instr_valid) begin
          {op, arg} <= instr_data;
          instr_req <= 1'b0;
          state <= DECODE;
        end
        DECODE: begin
          operand <= arg;
          OPR_sel <= (op >= 3'd1 && op <= 3'd4) ? op : 3'd0;
          state <= EXEC;
        end
        EXEC: begin
          reset_en <= op == 3'd1;
          wta_en <= op == 3'd2;
          wtr_en <= op == 3'd3;
          inc_en <= op == 3'd4;
          if (op == 3'd6) illegal <= 1'b1;
          if (op == 3'd7) begin
            halted <= 1'b1;
            state <= HALT;
          end else begin
            pc <= (op == 3'd5) ? PCW'(arg) : pc + 1'b1;
            state <= PULSE;
          end
        end
        PULSE: begin
          {reset_en, wta_en, wtr_en, inc_en} <= 4'b0;
          state <= WAIT;
        end
        WAIT: if (!dp_busy) begin
          OPR_sel <= 3'd0;
          instr_req <= 1'b1;
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
